// File: rtl/i2s_frame_transmitter.sv
// I2S / left-justified stereo serializer: a one-deep holding register feeds per-frame
// shadow registers, and the shadows are shifted out MSB first in fixed-width slots.
module i2s_frame_transmitter #(
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned SLOT_W  = 32,
  parameter int unsigned JUSTIFY = 0
) (
  input  logic                          serial_clk,
  input  logic                          reset,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [DATA_W-1:0]             s_left,
  input  logic [DATA_W-1:0]             s_right,
  output logic                          word_select,
  output logic                          sound_bit_out,
  output logic [$clog2(2*SLOT_W)-1:0]   bit_counter,
  output logic                          frame_start,
  output logic                          underrun
);

  localparam int unsigned CNT_W = $clog2(2*SLOT_W);
  localparam logic [CNT_W-1:0] LAST_CNT    = CNT_W'(2*SLOT_W - 1);
  localparam logic [CNT_W-1:0] RIGHT_START = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] WS_FIRST    = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] WS_LAST     = CNT_W'(2*SLOT_W - 2);

  logic [DATA_W-1:0] hold_l, hold_r, shadow_l, shadow_r;
  logic              hold_full;

  logic [DATA_W-1:0] hold_l_n, hold_r_n, shadow_l_n, shadow_r_n;
  logic              hold_full_n;
  logic [CNT_W-1:0]  cnt_n, offset;
  logic [DATA_W-1:0] sample, shifted;
  logic              wrap, accept, right_n;
  logic              ws_n, bit_n, fs_n, ur_n;

  // Next-state and next-output logic; all outputs are derived from the next count so they
  // update together on one edge.
  always_comb begin
    wrap        = (bit_counter == LAST_CNT);
    accept      = s_valid && s_ready;
    cnt_n       = wrap ? '0 : bit_counter + CNT_W'(1);
    hold_l_n    = hold_l;
    hold_r_n    = hold_r;
    hold_full_n = hold_full;
    shadow_l_n  = shadow_l;
    shadow_r_n  = shadow_r;

    if (wrap) begin
      shadow_l_n = hold_full ? hold_l : '0;
      shadow_r_n = hold_full ? hold_r : '0;
    end

    // A sample accepted on the wrap cycle lands in the holding register for the next frame.
    if (wrap && hold_full) begin
      hold_full_n = 1'b0;
    end else if (accept) begin
      hold_full_n = 1'b1;
      hold_l_n    = s_left;
      hold_r_n    = s_right;
    end

    right_n = (cnt_n >= RIGHT_START);
    offset  = right_n ? cnt_n - RIGHT_START : cnt_n;
    sample  = right_n ? shadow_r_n : shadow_l_n;
    // Shifting past the sample width naturally yields the zero padding.
    shifted = sample << offset;
    bit_n   = shifted[DATA_W-1];

    if (JUSTIFY == 0) begin
      ws_n = (cnt_n >= WS_FIRST) && (cnt_n <= WS_LAST);
    end else begin
      ws_n = right_n;
    end

    fs_n = (cnt_n == '0);
    ur_n = wrap && !hold_full;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge serial_clk) begin
    if (!reset) begin
      bit_counter   <= '0;
      hold_l        <= '0;
      hold_r        <= '0;
      hold_full     <= 1'b0;
      shadow_l      <= '0;
      shadow_r      <= '0;
      s_ready       <= 1'b0;
      word_select   <= 1'b0;
      sound_bit_out <= 1'b0;
      frame_start   <= 1'b1;
      underrun      <= 1'b0;
    end else begin
      bit_counter   <= cnt_n;
      hold_l        <= hold_l_n;
      hold_r        <= hold_r_n;
      hold_full     <= hold_full_n;
      shadow_l      <= shadow_l_n;
      shadow_r      <= shadow_r_n;
      s_ready       <= !hold_full_n;
      word_select   <= ws_n;
      sound_bit_out <= bit_n;
      frame_start   <= fs_n;
      underrun      <= ur_n;
    end
  end

endmodule

// File: tb/tb_i2s_frame_transmitter.sv
// Directed bench: Philips and left-justified instances share stimulus; every cycle of
// several frames is checked against hand-built 64-bit serial streams.
module tb_i2s_frame_transmitter;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned SLOT_W = 32;
  localparam int unsigned CNT_W  = $clog2(2*SLOT_W);

  logic              clk = 1'b0;
  logic              reset;
  logic              s_valid;
  logic [DATA_W-1:0] s_left, s_right;
  logic              s_ready, word_select, sound_bit_out, frame_start, underrun;
  logic [CNT_W-1:0]  bit_counter;
  logic              lj_ready, lj_ws, lj_bit, lj_fs, lj_ur;
  logic [CNT_W-1:0]  lj_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  i2s_frame_transmitter #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .JUSTIFY(0)) dut (
    .serial_clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_left(s_left), .s_right(s_right), .word_select(word_select),
    .sound_bit_out(sound_bit_out), .bit_counter(bit_counter),
    .frame_start(frame_start), .underrun(underrun)
  );

  i2s_frame_transmitter #(.DATA_W(DATA_W), .SLOT_W(SLOT_W), .JUSTIFY(1)) dut_lj (
    .serial_clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(lj_ready),
    .s_left(s_left), .s_right(s_right), .word_select(lj_ws),
    .sound_bit_out(lj_bit), .bit_counter(lj_cnt),
    .frame_start(lj_fs), .underrun(lj_ur)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and check both instances against the expected frame position.
  task automatic tick_check(input int ec, input logic [63:0] stream,
                            input logic er, input logic eu);
    logic eb, ews, ews_lj, efs;
    @(posedge clk);
    #1;
    eb     = stream[63-ec];
    ews    = (ec >= 31) && (ec <= 62);
    ews_lj = (ec >= 32);
    efs    = (ec == 0);
    chk($sformatf("cnt@%0d", ec), 64'(bit_counter), 64'(ec));
    chk($sformatf("bit@%0d", ec), 64'(sound_bit_out), 64'(eb));
    chk($sformatf("ws@%0d", ec), 64'(word_select), 64'(ews));
    chk($sformatf("ready@%0d", ec), 64'(s_ready), 64'(er));
    chk($sformatf("fs@%0d", ec), 64'(frame_start), 64'(efs));
    chk($sformatf("ur@%0d", ec), 64'(underrun), 64'(eu));
    chk($sformatf("lj_cnt@%0d", ec), 64'(lj_cnt), 64'(ec));
    chk($sformatf("lj_bit@%0d", ec), 64'(lj_bit), 64'(eb));
    chk($sformatf("lj_ws@%0d", ec), 64'(lj_ws), 64'(ews_lj));
    chk($sformatf("lj_ur@%0d", ec), 64'(lj_ur), 64'(eu));
  endtask

  task automatic reset_checks();
    chk("rst_cnt", 64'(bit_counter), 64'd0);
    chk("rst_ws", 64'(word_select), 64'd0);
    chk("rst_bit", 64'(sound_bit_out), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    chk("rst_fs", 64'(frame_start), 64'd1);
    chk("rst_ur", 64'(underrun), 64'd0);
    chk("rst_lj_ws", 64'(lj_ws), 64'd0);
    chk("rst_lj_ready", 64'(lj_ready), 64'd0);
  endtask

  initial begin
    logic [63:0] s1, s2, zero;
    s1   = {16'hA5F0, 16'h0000, 16'h0F0F, 16'h0000};
    s2   = {16'h8001, 16'h0000, 16'h7FFE, 16'h0000};
    zero = 64'd0;

    reset   = 1'b0;
    s_valid = 1'b0;
    s_left  = '0;
    s_right = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();

    // Frame 0: release, push first sample at count 1, then hold s_valid with a second one.
    reset = 1'b1;
    tick_check(1, zero, 1'b1, 1'b0);
    s_valid = 1'b1;
    s_left  = 16'hA5F0;
    s_right = 16'h0F0F;
    for (int c = 2; c < 64; c++) begin
      tick_check(c, zero, 1'b0, 1'b0);
      if (c == 2) begin
        s_left  = 16'hFFFF;
        s_right = 16'hFFFF;
      end
      if (c == 50) begin
        s_left  = 16'h8001;
        s_right = 16'h7FFE;
      end
    end

    // Frame 1: first sample on the wire; second accepted at count 0.
    tick_check(0, s1, 1'b1, 1'b0);
    tick_check(1, s1, 1'b0, 1'b0);
    s_valid = 1'b0;
    s_left  = 16'hFFFF;
    s_right = 16'hFFFF;
    for (int c = 2; c < 64; c++) tick_check(c, s1, 1'b0, 1'b0);

    // Frame 2: second sample.
    for (int c = 0; c < 64; c++) tick_check(c, s2, 1'b1, 1'b0);

    // Frames 3 and 4: starved.
    for (int f = 0; f < 2; f++)
      for (int c = 0; c < 64; c++) tick_check(c, zero, 1'b1, c == 0);

    // Frame 5: fill the holding register, then reset at count 40.
    for (int c = 0; c <= 40; c++) begin
      tick_check(c, zero, c <= 5, c == 0);
      if (c == 5) begin
        s_valid = 1'b1;
        s_left  = 16'h1234;
        s_right = 16'h5678;
      end
      if (c == 6) s_valid = 1'b0;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset_checks();
    reset = 1'b1;
    tick_check(1, zero, 1'b1, 1'b0);
    for (int c = 2; c < 64; c++) tick_check(c, zero, 1'b1, 1'b0);
    // The discarded sample must never appear; this frame is starved.
    for (int c = 0; c < 64; c++) tick_check(c, zero, 1'b1, c == 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
